// File: rtl/tinyqv_mem_arbiter.sv
// Memory arbiter: shares one memory port between a streaming instruction
// fetcher and a single-shot data port. Data beats fetch unless the previous
// grant was data (fairness bit). A watchdog aborts DATA/STOPPING when memory
// stops responding. Every output is registered.
module tinyqv_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        f_req,
  input  logic [22:0] f_addr,
  input  logic        f_stop,
  output logic        f_valid,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [27:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_start,
  output logic        m_stop,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [27:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_busy,
  input  logic        m_rvalid,
  input  logic        m_done,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, STOPPING} state_e;

  // Watchdog fires on the edge where the count would reach TIMEOUT, so the
  // abort pulse appears exactly TIMEOUT cycles after entering the state.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        fair_q, fair_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        m_start_q, m_start_d, m_stop_q, m_stop_d;
  logic        m_write_q, m_write_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [27:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        f_valid_q, f_valid_d;
  logic [15:0] f_rdata_q, f_rdata_d;
  logic        d_done_q, d_done_d, d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        wd_expire;

  assign wd_expire = (wdog_q == WD_LAST);

  // Next-state and registered-output logic; pulses default low, data holds.
  always_comb begin
    state_d   = state_q;
    fair_d    = fair_q;
    wdog_d    = wdog_q;
    m_start_d = 1'b0;
    m_stop_d  = 1'b0;
    m_write_d = m_write_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    f_valid_d = 1'b0;
    f_rdata_d = f_rdata_q;
    d_done_d  = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!fair_q || !f_req)) begin
          state_d   = DATA;
          wdog_d    = 8'd0;
          m_start_d = 1'b1;
          m_addr_d  = d_addr;
          m_write_d = d_write;
          m_size_d  = d_size;
          m_wdata_d = d_wdata;
        end else if (f_req) begin
          state_d   = FETCH;
          fair_d    = 1'b0;
          m_start_d = 1'b1;
          m_addr_d  = {4'b0, f_addr, 1'b0};
          m_write_d = 1'b0;
          m_size_d  = 2'b01;
        end
      end
      FETCH: begin
        f_valid_d = m_rvalid;
        f_rdata_d = m_rdata[15:0];
        // Any combination of end conditions produces a single stop.
        if (f_stop || !f_req || (d_req && !fair_q)) begin
          m_stop_d = 1'b1;
          state_d  = STOPPING;
          wdog_d   = 8'd0;
        end
      end
      DATA: begin
        wdog_d = wdog_q + 8'd1;
        // A completion arriving with the watchdog expiry still wins.
        if (m_done) begin
          d_rdata_d = m_rdata;
          d_done_d  = 1'b1;
          fair_d    = 1'b1;
          state_d   = IDLE;
        end else if (wd_expire) begin
          m_stop_d  = 1'b1;
          d_done_d  = 1'b1;
          d_err_d   = 1'b1;
          d_rdata_d = 32'd0;
          state_d   = IDLE;
        end
      end
      STOPPING: begin
        wdog_d = wdog_q + 8'd1;
        if (!m_busy) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          m_stop_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      fair_q    <= 1'b0;
      wdog_q    <= 8'd0;
      m_start_q <= 1'b0;
      m_stop_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= 28'd0;
      m_wdata_q <= 32'd0;
      f_valid_q <= 1'b0;
      f_rdata_q <= 16'd0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      fair_q    <= fair_d;
      wdog_q    <= wdog_d;
      m_start_q <= m_start_d;
      m_stop_q  <= m_stop_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      f_valid_q <= f_valid_d;
      f_rdata_q <= f_rdata_d;
      d_done_q  <= d_done_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_start = m_start_q;
  assign m_stop  = m_stop_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign f_valid = f_valid_q;
  assign f_rdata = f_rdata_q;
  assign d_done  = d_done_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: doc/tinyqv_mem_arbiter.md
TINYQV_MEM_ARBITER -- requirements
Module: tinyqv_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent in DATA or STOPPING before a forced abort (range 1-255).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port f_req, input, 1, fetch request, held high by the fetcher while it wants instructions.
REQ-005 SHALL have port f_addr, input, 23, fetch halfword address [23:1].
REQ-006 SHALL have port f_stop, input, 1, one-cycle pulse that ends the active fetch stream.
REQ-007 SHALL have port f_valid, output, 1, one-cycle pulse marking f_rdata as valid.
REQ-008 SHALL have port f_rdata, output, 16, instruction halfword.
REQ-009 SHALL have port d_req, input, 1, data request, held high until d_done.
REQ-010 SHALL have the following data-request ports, all inputs: d_write (1); d_size (2: 00 byte, 01 half, 10 word); d_addr (28); d_wdata (32).
REQ-011 SHALL have the following data-response ports, all outputs: d_done (1, one-cycle completion pulse); d_err (1, timeout flag, valid with d_done); d_rdata (32, read data).
REQ-012 SHALL have the following memory-command ports, all outputs: m_start (1); m_stop (1); m_write (1); m_size (2); m_addr (28); m_wdata (32).
REQ-013 SHALL have the following memory-status ports, all inputs: m_busy (1); m_rvalid (1, fetch beat); m_done (1, data complete); m_rdata (32).

Function
REQ-014 SHALL implement states IDLE, FETCH, DATA and STOPPING, held in a register.
REQ-015 SHALL hold a fairness bit fair, set on DATA completion and cleared on a FETCH grant.
REQ-016 In IDLE, SHALL go to DATA when d_req is high and (fair is 0 or f_req is 0); otherwise it SHALL go to FETCH when f_req is high; otherwise it SHALL stay in IDLE.
REQ-017 On a DATA grant, SHALL register m_addr=d_addr, m_write, m_size and m_wdata, and SHALL pulse m_start for exactly one cycle, in the cycle after the grant decision.
REQ-018 On a FETCH grant, SHALL register m_addr={4'b0,f_addr,1'b0}, m_write=0 and m_size=01, and SHALL pulse m_start for one cycle.
REQ-019 In FETCH, SHALL register f_valid<=m_rvalid and f_rdata<=m_rdata[15:0], giving one cycle of latency.
REQ-020 In FETCH, SHALL pulse m_stop for one cycle and enter STOPPING when f_stop is high, f_req is low, or d_req is high with fair=0; it SHALL issue one stop only when these conditions coincide.
REQ-021 SHALL discard m_rvalid in STOPPING, keeping f_valid=0.
REQ-022 SHALL leave STOPPING for IDLE on the first cycle in which m_busy=0.
REQ-023 In DATA, on m_done, SHALL register d_rdata<=m_rdata, pulse d_done for one cycle with d_err=0, set fair, and return to IDLE.
REQ-024 SHALL NOT stop or preempt a DATA transaction.
REQ-025 SHALL use an 8-bit watchdog counter that is cleared on entry to DATA or STOPPING and increments once per cycle while in those states.
REQ-026 When the watchdog reaches TIMEOUT, SHALL pulse m_stop, go to IDLE, and, if the state was DATA, pulse d_done with d_err=1 and d_rdata=0.
REQ-027 When m_done and the watchdog expiry occur in the same cycle, SHALL treat the transaction as a normal completion.
REQ-028 SHALL keep m_start, m_stop, f_valid and d_done low except for their defined single-cycle pulses.
REQ-029 SHALL ignore d_req deassertion before d_done; the transaction SHALL still complete.

Reset
REQ-030 While rstn is low, SHALL asynchronously force state=IDLE, fair=0, watchdog=0, and all outputs to 0, including m_addr, m_wdata, d_rdata and f_rdata.
REQ-031 SHALL begin in IDLE at the first rising edge after reset release, abandoning any transaction that was in flight with no d_done issued.

Verification
REQ-032 Scenario 1: f_req=1 from IDLE with f_addr=0x000040, then three m_rvalid beats of 0x1111/0x2222/0x3333 -> m_start with m_addr=0x0000080, followed by three f_valid pulses carrying the same values, one cycle late.
REQ-033 Scenario 2: d_req read with d_addr=0x8000010 during an active FETCH -> one m_stop pulse; after m_busy=0, m_start with m_addr=0x8000010; m_done with m_rdata=0xDEADBEEF -> d_done=1, d_err=0, d_rdata=0xDEADBEEF.
REQ-034 Scenario 3: f_req and d_req both high in IDLE, back to back -> data granted first, then fetch (fair=1), then data again.
REQ-035 Scenario 4: d_req write with m_done never asserted and TIMEOUT=4 -> m_stop and d_done with d_err=1 exactly 4 cycles after DATA entry; the state returns to IDLE.
REQ-036 Scenario 5: f_stop and d_req in the same FETCH cycle -> a single m_stop pulse, STOPPING, then the DATA grant.
REQ-037 Scenario 6: rstn pulsed low mid-DATA -> all outputs 0 immediately, no d_done, IDLE after release.
